// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- pipeline memory stage with an internal word-organised data RAM.
//
// Accepts one instruction per cycle from EX while idle. Non-memory work and
// stores retire to MEM/WB one cycle after acceptance. Loads read the RAM into
// a register, spend one cycle in LOAD_WAIT (holding EX via stall_req), then
// extract and extend the requested lane into MEM/WB. Misaligned accesses make
// no RAM access and instead produce a marked MEM/WB entry plus the address.
//
// Parameters
//   DEPTH  number of 32-bit RAM words (power of two)
//   AW     word-index width, log2(DEPTH)
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   ex_valid                EX presents an instruction
//   ex_alu_result           ALU result / byte address
//   ex_store_data           store data (rt)
//   ex_write_reg            destination register
//   ex_reg_write            instruction writes the register file
//   ex_mem_read/write       load / store (both set means store)
//   ex_mem_size             00 byte, 01 half, 10/11 word
//   ex_mem_unsigned         zero-extend loads
//   stall, flush            downstream hold / discard in-flight work
//   stall_req               upstream must hold (load in progress)
//   wb_valid, wb_reg_write  MEM/WB valid and register write enable
//   wb_write_reg            MEM/WB destination register
//   wb_write_data           MEM/WB result
//   misalign, bad_addr      misalignment pulse and last offending address
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic        stall,
    input  logic        flush,
    output logic        stall_req,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_write_data,
    output logic        misalign,
    output logic [31:0] bad_addr
);

    typedef enum logic [0:0] {
        StIdle,
        StLoadWait
    } state_e;

    state_e      state_q;

    // MEM/WB register
    logic        wb_valid_q;
    logic        wb_reg_write_q;
    logic [4:0]  wb_write_reg_q;
    logic [31:0] wb_write_data_q;
    logic        misalign_q;
    logic [31:0] bad_addr_q;

    // Load context captured at acceptance
    logic [1:0]  ld_off_q;
    logic [1:0]  ld_size_q;
    logic        ld_unsigned_q;
    logic [4:0]  ld_reg_q;
    logic        ld_reg_write_q;
    logic [31:0] ld_word_q;

    logic [31:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Decode of the presented instruction
    // ------------------------------------------------------------------
    logic          is_store;
    logic          is_load;
    logic          is_misaligned;
    logic          accept;
    logic [1:0]    addr_off;
    logic [AW-1:0] mem_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          ram_we;
    logic          ram_re;

    assign addr_off = ex_alu_result[1:0];
    assign mem_idx  = ex_alu_result[AW+1:2];

    // A simultaneous read+write request is resolved as a store.
    assign is_store = ex_mem_write;
    assign is_load  = ex_mem_read & ~ex_mem_write;

    always_comb begin
        is_misaligned = 1'b0;
        if (is_store || is_load) begin
            unique case (ex_mem_size)
                2'b00:   is_misaligned = 1'b0;
                2'b01:   is_misaligned = addr_off[0];
                default: is_misaligned = (addr_off != 2'b00);
            endcase
        end
    end

    assign accept = (state_q == StIdle) & ex_valid & ~stall & ~flush;

    // Reset is included so a store presented during reset never lands.
    assign ram_we = rst_n & accept & is_store & ~is_misaligned;
    assign ram_re = rst_n & accept & is_load & ~is_misaligned;

    // Little-endian lane enables; data is replicated so each enabled lane
    // picks up the low bytes of the store data.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = ex_store_data;
        unique case (ex_mem_size)
            2'b00: begin
                wr_be   = 4'b0001 << addr_off;
                wr_data = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                wr_be   = addr_off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{ex_store_data[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = ex_store_data;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data RAM: byte-lane writes, registered read; contents never reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (ram_re) begin
            ld_word_q <= mem_q[mem_idx];
        end
    end

    // ------------------------------------------------------------------
    // Lane extraction and extension of the registered load word
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data_d;

    always_comb begin
        unique case (ld_off_q)
            2'b00:   ld_byte = ld_word_q[7:0];
            2'b01:   ld_byte = ld_word_q[15:8];
            2'b10:   ld_byte = ld_word_q[23:16];
            default: ld_byte = ld_word_q[31:24];
        endcase
        ld_half = ld_off_q[1] ? ld_word_q[31:16] : ld_word_q[15:0];

        unique case (ld_size_q)
            2'b00:   ld_data_d = {{24{~ld_unsigned_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data_d = {{16{~ld_unsigned_q & ld_half[15]}}, ld_half};
            default: ld_data_d = ld_word_q;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and MEM/WB register. Priority: reset, flush, stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_write_reg_q  <= 5'd0;
            wb_write_data_q <= 32'd0;
            misalign_q      <= 1'b0;
            bad_addr_q      <= 32'd0;
            ld_off_q        <= 2'b00;
            ld_size_q       <= 2'b00;
            ld_unsigned_q   <= 1'b0;
            ld_reg_q        <= 5'd0;
            ld_reg_write_q  <= 1'b0;
        end else if (flush) begin
            // Any pending load is dropped by simply returning to idle.
            state_q        <= StIdle;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            misalign_q     <= 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    if (!ex_valid) begin
                        wb_valid_q     <= 1'b0;
                        wb_reg_write_q <= 1'b0;
                        misalign_q     <= 1'b0;
                    end else if (is_misaligned) begin
                        wb_valid_q      <= 1'b1;
                        wb_reg_write_q  <= 1'b0;
                        wb_write_reg_q  <= ex_write_reg;
                        wb_write_data_q <= ex_alu_result;
                        misalign_q      <= 1'b1;
                        bad_addr_q      <= ex_alu_result;
                    end else if (is_load) begin
                        state_q        <= StLoadWait;
                        wb_valid_q     <= 1'b0;
                        wb_reg_write_q <= 1'b0;
                        misalign_q     <= 1'b0;
                        ld_off_q       <= addr_off;
                        ld_size_q      <= ex_mem_size;
                        ld_unsigned_q  <= ex_mem_unsigned;
                        ld_reg_q       <= ex_write_reg;
                        ld_reg_write_q <= ex_reg_write;
                    end else begin
                        // Stores never write the register file.
                        wb_valid_q      <= 1'b1;
                        wb_reg_write_q  <= ex_reg_write & ~is_store;
                        wb_write_reg_q  <= ex_write_reg;
                        wb_write_data_q <= ex_alu_result;
                        misalign_q      <= 1'b0;
                    end
                end
                StLoadWait: begin
                    state_q         <= StIdle;
                    wb_valid_q      <= 1'b1;
                    wb_reg_write_q  <= ld_reg_write_q;
                    wb_write_reg_q  <= ld_reg_q;
                    wb_write_data_q <= ld_data_d;
                    misalign_q      <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall_req     = (state_q == StLoadWait);
    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_write_data = wb_write_data_q;
    assign misalign      = misalign_q;
    assign bad_addr      = bad_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed, table-driven bench for mem_stage (DEPTH=256).
// Each table entry is one instruction with hand-computed MEM/WB results;
// multi-cycle corners (stall, flush, reset mid-load) are written out by hand.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_write_reg;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned;
    logic        stall;
    logic        flush;
    logic        stall_req;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        misalign;
    logic [31:0] bad_addr;

    mem_stage #(
        .DEPTH(256),
        .AW   (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .ex_write_reg   (ex_write_reg),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_size    (ex_mem_size),
        .ex_mem_unsigned(ex_mem_unsigned),
        .stall          (stall),
        .flush          (flush),
        .stall_req      (stall_req),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_write_data  (wb_write_data),
        .misalign       (misalign),
        .bad_addr       (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        regw;
        logic        e_regw;
        logic [31:0] e_data;
        logic        chk_data;
        logic        e_mis;
    } vec_t;

    vec_t        vecs[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] last_bad = 32'd0;

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic regw, input logic e_regw,
                                input logic [31:0] e_data, input logic chk_data,
                                input logic e_mis);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
        v.addr = addr; v.sdata = sdata; v.regw = regw; v.e_regw = e_regw;
        v.e_data = e_data; v.chk_data = chk_data; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid        = 1'b0;
        ex_alu_result   = 32'd0;
        ex_store_data   = 32'd0;
        ex_write_reg    = 5'd0;
        ex_reg_write    = 1'b0;
        ex_mem_read     = 1'b0;
        ex_mem_write    = 1'b0;
        ex_mem_size     = 2'b00;
        ex_mem_unsigned = 1'b0;
    endtask

    task automatic drive(input vec_t v, input logic [4:0] wreg);
        ex_valid        = 1'b1;
        ex_alu_result   = v.addr;
        ex_store_data   = v.sdata;
        ex_write_reg    = wreg;
        ex_reg_write    = v.regw;
        ex_mem_read     = v.rd;
        ex_mem_write    = v.wr;
        ex_mem_size     = v.size;
        ex_mem_unsigned = v.uns;
    endtask

    // One instruction through the stage, then one empty cycle.
    task automatic run_vec(input vec_t v, input logic [4:0] wreg);
        drive(v, wreg);
        tick();
        idle_inputs();
        if (v.rd && !v.wr && !v.e_mis) begin
            chk({v.name, " stall_req"}, {31'd0, stall_req}, 32'd1);
            chk({v.name, " wb_valid_wait"}, {31'd0, wb_valid}, 32'd0);
            tick();
        end
        if (v.e_mis) last_bad = v.addr;
        chk({v.name, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({v.name, " wb_reg_write"}, {31'd0, wb_reg_write}, {31'd0, v.e_regw});
        chk({v.name, " misalign"}, {31'd0, misalign}, {31'd0, v.e_mis});
        chk({v.name, " bad_addr"}, bad_addr, last_bad);
        chk({v.name, " stall_req_done"}, {31'd0, stall_req}, 32'd0);
        if (v.chk_data) chk({v.name, " wb_write_data"}, wb_write_data, v.e_data);
        if (v.e_regw) chk({v.name, " wb_write_reg"}, {27'd0, wb_write_reg}, {27'd0, wreg});
        tick();
        chk({v.name, " idle_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({v.name, " idle_misalign"}, {31'd0, misalign}, 32'd0);
    endtask

    initial begin
        // name rd wr size uns addr sdata regw e_regw e_data chk mis
        vecs.push_back(mk("sw_20",    0, 1, 2'b10, 0, 32'h20,   32'h1111_1111, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sh_22",    0, 1, 2'b01, 0, 32'h22,   32'h0000_BEEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw_20",    1, 0, 2'b10, 0, 32'h20,   0, 1, 1, 32'hBEEF_1111, 1, 0));
        vecs.push_back(mk("lh_22",    1, 0, 2'b01, 0, 32'h22,   0, 1, 1, 32'hFFFF_BEEF, 1, 0));
        vecs.push_back(mk("lhu_22",   1, 0, 2'b01, 1, 32'h22,   0, 1, 1, 32'h0000_BEEF, 1, 0));
        vecs.push_back(mk("lh_20",    1, 0, 2'b01, 0, 32'h20,   0, 1, 1, 32'h0000_1111, 1, 0));
        vecs.push_back(mk("sw_10",    0, 1, 2'b10, 0, 32'h10,   32'h8000_00FF, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lb_10",    1, 0, 2'b00, 0, 32'h10,   0, 1, 1, 32'hFFFF_FFFF, 1, 0));
        vecs.push_back(mk("lbu_10",   1, 0, 2'b00, 1, 32'h10,   0, 1, 1, 32'h0000_00FF, 1, 0));
        vecs.push_back(mk("lb_13",    1, 0, 2'b00, 0, 32'h13,   0, 1, 1, 32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk("sb_11",    0, 1, 2'b00, 0, 32'h11,   32'hFFFF_FF5A, 1, 0, 0, 0, 0));
        vecs.push_back(mk("lw_10",    1, 0, 2'b10, 0, 32'h10,   0, 1, 1, 32'h8000_5AFF, 1, 0));
        vecs.push_back(mk("add",      0, 0, 2'b10, 0, 32'h1234, 0, 1, 1, 32'h0000_1234, 1, 0));
        vecs.push_back(mk("alu_nowr", 0, 0, 2'b10, 0, 32'h77,   0, 0, 0, 32'h0000_0077, 1, 0));
        vecs.push_back(mk("lw_13_mis",1, 0, 2'b10, 0, 32'h13,   0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("lw_10_b",  1, 0, 2'b10, 0, 32'h10,   0, 1, 1, 32'h8000_5AFF, 1, 0));
        vecs.push_back(mk("sw_400",   0, 1, 2'b10, 0, 32'h400,  32'hA5A5_A5A5, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw_0",     1, 0, 2'b10, 0, 32'h0,    0, 1, 1, 32'hA5A5_A5A5, 1, 0));
        vecs.push_back(mk("rdwr_30",  1, 1, 2'b10, 0, 32'h30,   32'hCAFE_F00D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("lw_30",    1, 0, 2'b10, 0, 32'h30,   0, 1, 1, 32'hCAFE_F00D, 1, 0));
        vecs.push_back(mk("sh_21_mis",0, 1, 2'b01, 0, 32'h21,   32'h0000_DEAD, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lw_20_b",  1, 0, 2'b10, 0, 32'h20,   0, 1, 1, 32'hBEEF_1111, 1, 0));
        vecs.push_back(mk("sw11_40",  0, 1, 2'b11, 0, 32'h40,   32'h0102_0304, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw11_40",  1, 0, 2'b11, 0, 32'h40,   0, 1, 1, 32'h0102_0304, 1, 0));
        vecs.push_back(mk("lb_42",    1, 0, 2'b00, 0, 32'h42,   0, 1, 1, 32'h0000_0002, 1, 0));
        vecs.push_back(mk("lh_42",    1, 0, 2'b01, 0, 32'h42,   0, 1, 1, 32'h0000_0102, 1, 0));
        vecs.push_back(mk("lw11_41",  1, 0, 2'b11, 0, 32'h41,   0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("lw_1020",  1, 0, 2'b10, 0, 32'h1020, 0, 1, 1, 32'hBEEF_1111, 1, 0));

        idle_inputs();
        stall = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst stall_req", {31'd0, stall_req}, 32'd0);
        chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        chk("rst wb_write_reg", {27'd0, wb_write_reg}, 32'd0);
        chk("rst wb_write_data", wb_write_data, 32'd0);
        chk("rst misalign", {31'd0, misalign}, 32'd0);
        chk("rst bad_addr", bad_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 5'(i + 1));
        end

        // Flush while a load waits: no MEM/WB entry, back to idle.
        drive(mk("lw_fl", 1, 0, 2'b10, 0, 32'h20, 0, 1, 1, 0, 0, 0), 5'd9);
        tick();
        idle_inputs();
        chk("flush pre stall_req", {31'd0, stall_req}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush stall_req", {31'd0, stall_req}, 32'd0);
        chk("flush wb_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("flush after wb_valid", {31'd0, wb_valid}, 32'd0);

        // Stall holds off acceptance of an ALU result, then holds MEM/WB.
        drive(mk("add_st", 0, 0, 2'b10, 0, 32'h1234, 0, 1, 1, 0, 0, 0), 5'd3);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall no accept", {31'd0, wb_valid}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall release valid", {31'd0, wb_valid}, 32'd1);
        chk("stall release data", wb_write_data, 32'h0000_1234);
        chk("stall release reg", {27'd0, wb_write_reg}, 32'd3);
        ex_alu_result = 32'h9999;
        stall = 1'b1;
        tick();
        chk("stall hold valid", {31'd0, wb_valid}, 32'd1);
        chk("stall hold data", wb_write_data, 32'h0000_1234);
        stall = 1'b0;
        idle_inputs();
        tick();
        chk("stall end valid", {31'd0, wb_valid}, 32'd0);

        // Stall during LOAD_WAIT keeps the load pending.
        drive(mk("lw_st", 1, 0, 2'b10, 0, 32'h20, 0, 1, 1, 0, 0, 0), 5'd7);
        tick();
        idle_inputs();
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("ldstall stall_req", {31'd0, stall_req}, 32'd1);
            chk("ldstall wb_valid", {31'd0, wb_valid}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("ldstall valid", {31'd0, wb_valid}, 32'd1);
        chk("ldstall data", wb_write_data, 32'hBEEF_1111);
        chk("ldstall stall_req done", {31'd0, stall_req}, 32'd0);
        tick();

        // Reset during LOAD_WAIT aborts the load; RAM survives reset.
        drive(mk("lw_rst", 1, 0, 2'b10, 0, 32'h20, 0, 1, 1, 0, 0, 0), 5'd4);
        tick();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_bad = 32'd0;
        chk("rstld stall_req", {31'd0, stall_req}, 32'd0);
        chk("rstld wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstld bad_addr", bad_addr, 32'd0);
        tick();
        chk("rstld after wb_valid", {31'd0, wb_valid}, 32'd0);
        run_vec(mk("lw_20_rst", 1, 0, 2'b10, 0, 32'h20, 0, 1, 1, 32'hBEEF_1111, 1, 0), 5'd4);

        // Stores under flush or stall must not reach the RAM.
        run_vec(mk("sw_50", 0, 1, 2'b10, 0, 32'h50, 32'h1234_5678, 0, 0, 0, 0, 0), 5'd1);
        drive(mk("sw_50_fl", 0, 1, 2'b10, 0, 32'h50, 32'hDEAD_BEEF, 0, 0, 0, 0, 0), 5'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush store wb_valid", {31'd0, wb_valid}, 32'd0);
        stall = 1'b1;
        ex_store_data = 32'hFEED_0000;
        tick();
        stall = 1'b0;
        idle_inputs();
        tick();
        run_vec(mk("lw_50", 1, 0, 2'b10, 0, 32'h50, 0, 1, 1, 32'h1234_5678, 1, 0), 5'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
